// File: rtl/midi_voice_pkg.sv
// Shared types and widths for the MIDI voice allocator.
//   alloc_state_t : allocator FSM states (RELEASE exists only with VOICE_SUSTAIN_EN)
//   midi_event_t  : latched note event payload
// Optional feature macro: VOICE_SUSTAIN_EN
package midi_voice_pkg;

    localparam int unsigned NOTE_W = 8;
    localparam int unsigned VEL_W  = 8;
    localparam int unsigned CHAN_W = 4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SCAN    = 2'd1,
        S_COMMIT  = 2'd2
`ifdef VOICE_SUSTAIN_EN
        ,
        S_RELEASE = 2'd3
`endif
    } alloc_state_t;

    typedef struct packed {
        logic              status;
        logic [NOTE_W-1:0] note;
        logic [VEL_W-1:0]  velocity;
        logic [CHAN_W-1:0] channel;
    } midi_event_t;

endpackage

// File: rtl/midi_voice_slot.sv
// One synth voice slot: gate, note, velocity, channel and saturating age.
// Ports:
//   clk_in, rst_n_in      clock, async active-low reset
//   i_load                start/retrigger: gate=1, load note/vel/chan, age=0
//   i_release             gate=0 (note/vel/chan hold)
//   i_age_inc             age+1 if gated, saturating
//   i_sus_set             (VOICE_SUSTAIN_EN) mark slot as held by sustain pedal
//   i_note/i_vel/i_chan   payload for i_load
//   o_gate/o_note/o_vel/o_chan/o_age(/o_sustained)  slot state
// Optional feature macro: VOICE_SUSTAIN_EN
module midi_voice_slot
    import midi_voice_pkg::*;
#(
    parameter int unsigned AGE_W = 4
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              i_load,
    input  logic              i_release,
    input  logic              i_age_inc,
`ifdef VOICE_SUSTAIN_EN
    input  logic              i_sus_set,
    output logic              o_sustained,
`endif
    input  logic [NOTE_W-1:0] i_note,
    input  logic [VEL_W-1:0]  i_vel,
    input  logic [CHAN_W-1:0] i_chan,
    output logic              o_gate,
    output logic [NOTE_W-1:0] o_note,
    output logic [VEL_W-1:0]  o_vel,
    output logic [CHAN_W-1:0] o_chan,
    output logic [AGE_W-1:0]  o_age
);

    logic              r_gate;
    logic [NOTE_W-1:0] r_note;
    logic [VEL_W-1:0]  r_vel;
    logic [CHAN_W-1:0] r_chan;
    logic [AGE_W-1:0]  r_age;
`ifdef VOICE_SUSTAIN_EN
    logic              r_sustained;
`endif

    // Slot state; load beats release beats sustain-mark/ageing
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_gate <= 1'b0;
            r_note <= '0;
            r_vel  <= '0;
            r_chan <= '0;
            r_age  <= '0;
`ifdef VOICE_SUSTAIN_EN
            r_sustained <= 1'b0;
`endif
        end else if (i_load) begin
            r_gate <= 1'b1;
            r_note <= i_note;
            r_vel  <= i_vel;
            r_chan <= i_chan;
            r_age  <= '0;
`ifdef VOICE_SUSTAIN_EN
            r_sustained <= 1'b0;
`endif
        end else if (i_release) begin
            r_gate <= 1'b0;
`ifdef VOICE_SUSTAIN_EN
            r_sustained <= 1'b0;
`endif
        end else begin
`ifdef VOICE_SUSTAIN_EN
            if (i_sus_set) begin
                r_sustained <= 1'b1;
            end
`endif
            if (i_age_inc && r_gate && (r_age != {AGE_W{1'b1}})) begin
                r_age <= r_age + AGE_W'(1);
            end
        end
    end

    assign o_gate = r_gate;
    assign o_note = r_note;
    assign o_vel  = r_vel;
    assign o_chan = r_chan;
    assign o_age  = r_age;
`ifdef VOICE_SUSTAIN_EN
    assign o_sustained = r_sustained;
`endif

endmodule

// File: rtl/midi_voice_allocator.sv
// Polyphonic voice allocator: assigns note-on/off events to NUM_VOICES slots
// (retrigger on match, else lowest free slot, else steal the oldest gated slot).
// One slot is examined per cycle; update pulse NUM_VOICES+2 cycles after the strobe.
// Ports:
//   clk_in, rst_n_in        clock, async active-low reset
//   event_*_in              1-cycle note event strobe and payload
//   sustain_in              sustain pedal level (VOICE_SUSTAIN_EN only)
//   ready_out               high while IDLE and able to accept an event
//   voice_*_out             per-slot gate and packed note/velocity/channel
//   voice_update_out        1-cycle pulse when a slot changed, slot in voice_index_out
//   steal_out               pulses with voice_update_out when a voice was stolen
//   overflow_out            sticky: event arrived while ready_out was low
// Optional feature macro: VOICE_SUSTAIN_EN (sustain pedal hold/release)
module midi_voice_allocator
    import midi_voice_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 8,
    parameter int unsigned AGE_W      = 4
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic                         event_valid_in,
    input  logic                         event_status_in,
    input  logic [NOTE_W-1:0]            event_note_in,
    input  logic [VEL_W-1:0]             event_velocity_in,
    input  logic [CHAN_W-1:0]            event_channel_in,
    input  logic                         sustain_in,
    output logic                         ready_out,
    output logic [NUM_VOICES-1:0]        voice_gate_out,
    output logic [NOTE_W*NUM_VOICES-1:0] voice_note_out,
    output logic [VEL_W*NUM_VOICES-1:0]  voice_velocity_out,
    output logic [CHAN_W*NUM_VOICES-1:0] voice_channel_out,
    output logic                         voice_update_out,
    output logic [$clog2(NUM_VOICES)-1:0] voice_index_out,
    output logic                         steal_out,
    output logic                         overflow_out
);

    localparam int unsigned IDX_W = $clog2(NUM_VOICES);

    alloc_state_t     r_state;
    midi_event_t      r_event;
    logic [IDX_W-1:0] r_idx;
    logic             r_ready;
    logic             r_update;
    logic             r_steal;
    logic [IDX_W-1:0] r_index;
    logic             r_overflow;

    // Scan results
    logic             r_match_found;
    logic [IDX_W-1:0] r_match_idx;
    logic             r_free_found;
    logic [IDX_W-1:0] r_free_idx;
    logic             r_old_found;
    logic [IDX_W-1:0] r_old_idx;
    logic [AGE_W-1:0] r_old_age;

    // Slot interface
    logic [NUM_VOICES-1:0] w_gate;
    logic [NOTE_W-1:0]     w_note [NUM_VOICES];
    logic [VEL_W-1:0]      w_vel  [NUM_VOICES];
    logic [CHAN_W-1:0]     w_chan [NUM_VOICES];
    logic [AGE_W-1:0]      w_age  [NUM_VOICES];
    logic [NUM_VOICES-1:0] w_load;
    logic [NUM_VOICES-1:0] w_release;
    logic [NUM_VOICES-1:0] w_age_inc;

    logic                  w_sel_gate;
    logic [NOTE_W-1:0]     w_sel_note;
    logic [CHAN_W-1:0]     w_sel_chan;
    logic [AGE_W-1:0]      w_sel_age;
    logic                  w_is_on;
    logic                  w_do_update;
    logic                  w_do_steal;
    logic [IDX_W-1:0]      w_target;
    logic                  w_pend_next;

`ifdef VOICE_SUSTAIN_EN
    logic [NUM_VOICES-1:0] w_sustained;
    logic [NUM_VOICES-1:0] w_sus_set;
    logic                  w_sus_fall;
    logic                  r_sus_d;
    logic                  r_pending;
    logic                  r_sus_found;
    logic [IDX_W-1:0]      r_sus_idx;
    logic [AGE_W-1:0]      r_sus_age;

    assign w_sus_fall  = r_sus_d & ~sustain_in;
    // Release request still outstanding after this cycle
    assign w_pend_next = r_pending | w_sus_fall;
`else
    logic w_unused_sustain;
    assign w_unused_sustain = sustain_in;
    assign w_pend_next      = 1'b0;
`endif

    // Voice slots
    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_slot
        midi_voice_slot #(
            .AGE_W (AGE_W)
        ) u_slot (
            .clk_in      (clk_in),
            .rst_n_in    (rst_n_in),
            .i_load      (w_load[gi]),
            .i_release   (w_release[gi]),
            .i_age_inc   (w_age_inc[gi]),
`ifdef VOICE_SUSTAIN_EN
            .i_sus_set   (w_sus_set[gi]),
            .o_sustained (w_sustained[gi]),
`endif
            .i_note      (r_event.note),
            .i_vel       (r_event.velocity),
            .i_chan      (r_event.channel),
            .o_gate      (w_gate[gi]),
            .o_note      (w_note[gi]),
            .o_vel       (w_vel[gi]),
            .o_chan      (w_chan[gi]),
            .o_age       (w_age[gi])
        );

        assign voice_note_out[NOTE_W*gi +: NOTE_W]     = w_note[gi];
        assign voice_velocity_out[VEL_W*gi +: VEL_W]   = w_vel[gi];
        assign voice_channel_out[CHAN_W*gi +: CHAN_W]  = w_chan[gi];
    end

    // Slot currently under scan
    assign w_sel_gate = w_gate[r_idx];
    assign w_sel_note = w_note[r_idx];
    assign w_sel_chan = w_chan[r_idx];
    assign w_sel_age  = w_age[r_idx];

    // Velocity-0 note-on behaves as note-off
    assign w_is_on = r_event.status && (r_event.velocity != '0);

    // Slot strobes and update decision for COMMIT / RELEASE
    always_comb begin
        w_load      = '0;
        w_release   = '0;
        w_age_inc   = '0;
        w_do_update = 1'b0;
        w_do_steal  = 1'b0;
        w_target    = '0;
`ifdef VOICE_SUSTAIN_EN
        w_sus_set   = '0;
`endif
        if (r_state == S_COMMIT) begin
            if (w_is_on) begin
                w_do_update = 1'b1;
                if (r_match_found) begin
                    w_target = r_match_idx;
                end else if (r_free_found) begin
                    w_target = r_free_idx;
                end else begin
                    w_do_steal = 1'b1;
`ifdef VOICE_SUSTAIN_EN
                    w_target = r_sus_found ? r_sus_idx : r_old_idx;
`else
                    w_target = r_old_idx;
`endif
                end
                w_load[w_target] = 1'b1;
                w_age_inc        = ~w_load;
            end else if (r_match_found) begin
`ifdef VOICE_SUSTAIN_EN
                if (sustain_in) begin
                    w_sus_set[r_match_idx] = 1'b1;
                end else begin
                    w_release[r_match_idx] = 1'b1;
                    w_do_update            = 1'b1;
                    w_target               = r_match_idx;
                end
`else
                w_release[r_match_idx] = 1'b1;
                w_do_update            = 1'b1;
                w_target               = r_match_idx;
`endif
            end
        end
`ifdef VOICE_SUSTAIN_EN
        else if (r_state == S_RELEASE) begin
            w_release   = w_sustained;
            w_do_update = |w_sustained;
            for (int i = NUM_VOICES - 1; i >= 0; i--) begin
                if (w_sustained[i]) begin
                    w_target = IDX_W'(i);
                end
            end
        end
`endif
    end

    // Allocator FSM, scan tracking and registered status outputs
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state       <= S_IDLE;
            r_event       <= '0;
            r_idx         <= '0;
            r_ready       <= 1'b1;
            r_update      <= 1'b0;
            r_steal       <= 1'b0;
            r_index       <= '0;
            r_overflow    <= 1'b0;
            r_match_found <= 1'b0;
            r_match_idx   <= '0;
            r_free_found  <= 1'b0;
            r_free_idx    <= '0;
            r_old_found   <= 1'b0;
            r_old_idx     <= '0;
            r_old_age     <= '0;
`ifdef VOICE_SUSTAIN_EN
            r_sus_d       <= 1'b0;
            r_pending     <= 1'b0;
            r_sus_found   <= 1'b0;
            r_sus_idx     <= '0;
            r_sus_age     <= '0;
`endif
        end else begin
            r_update <= 1'b0;
            r_steal  <= 1'b0;
            if (event_valid_in && !r_ready) begin
                r_overflow <= 1'b1;
            end
`ifdef VOICE_SUSTAIN_EN
            r_sus_d <= sustain_in;
            if (w_sus_fall) begin
                r_pending <= 1'b1;
            end
`endif
            unique case (r_state)
                S_IDLE: begin
`ifdef VOICE_SUSTAIN_EN
                    if (r_pending) begin
                        r_state <= S_RELEASE;
                        r_ready <= 1'b0;
                    end else
`endif
                    if (event_valid_in) begin
                        r_event.status   <= event_status_in;
                        r_event.note     <= event_note_in;
                        r_event.velocity <= event_velocity_in;
                        r_event.channel  <= event_channel_in;
                        r_idx            <= '0;
                        r_match_found    <= 1'b0;
                        r_free_found     <= 1'b0;
                        r_old_found      <= 1'b0;
                        r_old_age        <= '0;
`ifdef VOICE_SUSTAIN_EN
                        r_sus_found      <= 1'b0;
                        r_sus_age        <= '0;
`endif
                        r_ready          <= 1'b0;
                        r_state          <= S_SCAN;
                    end else begin
                        r_ready <= !w_pend_next;
                    end
                end
                S_SCAN: begin
                    if (w_sel_gate && (w_sel_note == r_event.note) &&
                        (w_sel_chan == r_event.channel) && !r_match_found) begin
                        r_match_found <= 1'b1;
                        r_match_idx   <= r_idx;
                    end
                    if (!w_sel_gate && !r_free_found) begin
                        r_free_found <= 1'b1;
                        r_free_idx   <= r_idx;
                    end
                    // Strict compare keeps the lowest index on age ties
                    if (w_sel_gate && (!r_old_found || (w_sel_age > r_old_age))) begin
                        r_old_found <= 1'b1;
                        r_old_idx   <= r_idx;
                        r_old_age   <= w_sel_age;
                    end
`ifdef VOICE_SUSTAIN_EN
                    if (w_sustained[r_idx] && (!r_sus_found || (w_sel_age > r_sus_age))) begin
                        r_sus_found <= 1'b1;
                        r_sus_idx   <= r_idx;
                        r_sus_age   <= w_sel_age;
                    end
`endif
                    if (r_idx == IDX_W'(NUM_VOICES - 1)) begin
                        r_state <= S_COMMIT;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                S_COMMIT: begin
                    r_update <= w_do_update;
                    r_steal  <= w_do_steal;
                    if (w_do_update) begin
                        r_index <= w_target;
                    end
                    r_ready <= !w_pend_next;
                    r_state <= S_IDLE;
                end
`ifdef VOICE_SUSTAIN_EN
                S_RELEASE: begin
                    r_update  <= w_do_update;
                    if (w_do_update) begin
                        r_index <= w_target;
                    end
                    r_pending <= w_sus_fall;
                    r_ready   <= !w_sus_fall;
                    r_state   <= S_IDLE;
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign ready_out        = r_ready;
    assign voice_gate_out   = w_gate;
    assign voice_update_out = r_update;
    assign voice_index_out  = r_index;
    assign steal_out        = r_steal;
    assign overflow_out     = r_overflow;

endmodule

// File: tb/tb_midi_voice_allocator.sv
module tb_midi_voice_allocator;

    localparam int NV = 4;

    logic          clk;
    logic          rst_n;
    logic          valid;
    logic          status;
    logic [7:0]    note;
    logic [7:0]    vel;
    logic [3:0]    chan;
    logic          sustain;
    logic          ready_out;
    logic [NV-1:0] gate_out;
    logic [8*NV-1:0] note_out;
    logic [8*NV-1:0] vel_out;
    logic [4*NV-1:0] chan_out;
    logic          update_out;
    logic [1:0]    index_out;
    logic          steal_out;
    logic          overflow_out;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit       m_gate [NV];
    int       m_note [NV];
    int       m_vel  [NV];
    int       m_chan [NV];
    int       m_age  [NV];

    midi_voice_allocator #(.NUM_VOICES(NV), .AGE_W(4)) dut (
        .clk_in             (clk),
        .rst_n_in           (rst_n),
        .event_valid_in     (valid),
        .event_status_in    (status),
        .event_note_in      (note),
        .event_velocity_in  (vel),
        .event_channel_in   (chan),
        .sustain_in         (sustain),
        .ready_out          (ready_out),
        .voice_gate_out     (gate_out),
        .voice_note_out     (note_out),
        .voice_velocity_out (vel_out),
        .voice_channel_out  (chan_out),
        .voice_update_out   (update_out),
        .voice_index_out    (index_out),
        .steal_out          (steal_out),
        .overflow_out       (overflow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_gate[i] = 0; m_note[i] = 0; m_vel[i] = 0; m_chan[i] = 0; m_age[i] = 0;
        end
    endtask

    // Allocation rules: retrigger match, else lowest free, else oldest gated
    task automatic model_apply(input bit st, input int n, input int v, input int c,
                               output bit upd, output bit stl, output int idx);
        int match = -1;
        int free  = -1;
        int old   = -1;
        upd = 0; stl = 0; idx = 0;
        for (int i = 0; i < NV; i++) begin
            if (m_gate[i] && m_note[i] == n && m_chan[i] == c && match < 0) match = i;
            if (!m_gate[i] && free < 0) free = i;
            if (m_gate[i] && (old < 0 || m_age[i] > m_age[old])) old = i;
        end
        if (st && v != 0) begin
            upd = 1;
            if (match >= 0) idx = match;
            else if (free >= 0) idx = free;
            else begin idx = old; stl = 1; end
            for (int i = 0; i < NV; i++)
                if (i != idx && m_gate[i] && m_age[i] < 15) m_age[i]++;
            m_gate[idx] = 1; m_note[idx] = n; m_vel[idx] = v; m_chan[idx] = c; m_age[idx] = 0;
        end else if (match >= 0) begin
            upd = 1; idx = match; m_gate[match] = 0;
        end
    endtask

    task automatic check_vs_model(input string tag);
        logic [NV-1:0]   eg;
        logic [8*NV-1:0] en;
        logic [8*NV-1:0] ev;
        logic [4*NV-1:0] ec;
        for (int i = 0; i < NV; i++) begin
            eg[i] = m_gate[i];
            en[8*i +: 8] = 8'(m_note[i]);
            ev[8*i +: 8] = 8'(m_vel[i]);
            ec[4*i +: 4] = 4'(m_chan[i]);
        end
        check({tag, "_gate"}, 64'(gate_out), 64'(eg));
        check({tag, "_note"}, 64'(note_out), 64'(en));
        check({tag, "_vel"},  64'(vel_out),  64'(ev));
        check({tag, "_chan"}, 64'(chan_out), 64'(ec));
    endtask

    task automatic do_reset();
        valid = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    // Drive one event when ready; lat = cycle of update pulse after strobe cycle (-1 if none)
    task automatic send_event(input bit st, input logic [7:0] n, input logic [7:0] v,
                              input logic [3:0] c, output bit got_upd, output bit got_stl,
                              output int got_idx, output int lat, output bit busy_seen);
        int w = 0;
        while (!ready_out && w < 50) begin
            @(posedge clk); #1; w++;
        end
        if (!ready_out) begin
            n_checks++; n_errors++;
            $display("FAIL ready_timeout: ready_out stayed 0");
        end
        @(negedge clk);
        valid = 1; status = st; note = n; vel = v; chan = c;
        @(posedge clk);
        #1;
        valid = 0;
        busy_seen = !ready_out;
        got_upd = 0; got_stl = 0; got_idx = 0; lat = -1;
        for (int k = 1; k <= NV + 4; k++) begin
            @(posedge clk);
            #1;
            if (update_out && !got_upd) begin
                got_upd = 1; got_stl = steal_out; got_idx = int'(index_out); lat = k + 1;
            end
        end
    endtask

    typedef struct {
        bit         st;
        logic [7:0] n;
        logic [7:0] v;
        logic [3:0] c;
        bit         upd;
        bit         stl;
        int         idx;
        logic [3:0] gate;
    } vec_t;

    vec_t tbl [10];

    initial begin
        bit   gu, gs, eu, es, bz;
        int   gi, lat, ei;
        logic [7:0] rn, rv;
        logic [3:0] rc;
        bit   rs;

        valid = 0; status = 0; note = 0; vel = 0; chan = 0; sustain = 0; rst_n = 1;
        tbl[0] = '{1'b1, 8'd60, 8'd100, 4'd0, 1'b1, 1'b0, 0, 4'b0001};
        tbl[1] = '{1'b1, 8'd62, 8'd90,  4'd1, 1'b1, 1'b0, 1, 4'b0011};
        tbl[2] = '{1'b1, 8'd64, 8'd80,  4'd0, 1'b1, 1'b0, 2, 4'b0111};
        tbl[3] = '{1'b1, 8'd65, 8'd70,  4'd0, 1'b1, 1'b0, 3, 4'b1111};
        tbl[4] = '{1'b1, 8'd67, 8'd60,  4'd0, 1'b1, 1'b1, 0, 4'b1111};
        tbl[5] = '{1'b0, 8'd70, 8'd0,   4'd0, 1'b0, 1'b0, 0, 4'b1111};
        tbl[6] = '{1'b1, 8'd62, 8'd0,   4'd1, 1'b1, 1'b0, 1, 4'b1101};
        tbl[7] = '{1'b1, 8'd71, 8'd50,  4'd0, 1'b1, 1'b0, 1, 4'b1111};
        tbl[8] = '{1'b1, 8'd64, 8'd120, 4'd0, 1'b1, 1'b0, 2, 4'b1111};
        tbl[9] = '{1'b1, 8'd80, 8'd40,  4'd0, 1'b1, 1'b1, 3, 4'b1111};

        // Reset state
        do_reset();
        model_reset();
        check("rst_ready", 64'(ready_out), 64'd1);
        check("rst_gate", 64'(gate_out), 64'd0);
        check("rst_note", 64'(note_out), 64'd0);
        check("rst_vel", 64'(vel_out), 64'd0);
        check("rst_chan", 64'(chan_out), 64'd0);
        check("rst_update", 64'(update_out), 64'd0);
        check("rst_index", 64'(index_out), 64'd0);
        check("rst_steal", 64'(steal_out), 64'd0);
        check("rst_overflow", 64'(overflow_out), 64'd0);

        // Directed table
        for (int r = 0; r < 10; r++) begin
            send_event(tbl[r].st, tbl[r].n, tbl[r].v, tbl[r].c, gu, gs, gi, lat, bz);
            model_apply(tbl[r].st, int'(tbl[r].n), int'(tbl[r].v), int'(tbl[r].c), eu, es, ei);
            check($sformatf("tbl%0d_busy", r), 64'(bz), 64'd1);
            check($sformatf("tbl%0d_update", r), 64'(gu), 64'(tbl[r].upd));
            if (tbl[r].upd) begin
                check($sformatf("tbl%0d_latency", r), 64'(lat), 64'd6);
                check($sformatf("tbl%0d_steal", r), 64'(gs), 64'(tbl[r].stl));
                check($sformatf("tbl%0d_index", r), 64'(gi), 64'(tbl[r].idx));
            end
            check($sformatf("tbl%0d_gate", r), 64'(gate_out), 64'(tbl[r].gate));
            check_vs_model($sformatf("tbl%0d", r));
            check($sformatf("tbl%0d_ready", r), 64'(ready_out), 64'd1);
        end

        // Velocity-0 note-on releases and holds note
        do_reset();
        send_event(1'b1, 8'd60, 8'd100, 4'd0, gu, gs, gi, lat, bz);
        send_event(1'b1, 8'd60, 8'd0, 4'd0, gu, gs, gi, lat, bz);
        check("v0_update", 64'(gu), 64'd1);
        check("v0_steal", 64'(gs), 64'd0);
        check("v0_index", 64'(gi), 64'd0);
        check("v0_gate", 64'(gate_out), 64'd0);
        check("v0_note_hold", 64'(note_out), 64'd60);

        // Overflow: second strobe 2 cycles after the first is dropped
        do_reset();
        @(negedge clk);
        valid = 1; status = 1; note = 8'd60; vel = 8'd100; chan = 4'd0;
        @(posedge clk); #1; valid = 0;
        @(posedge clk); #1;
        valid = 1; status = 1; note = 8'd70; vel = 8'd90; chan = 4'd2;
        @(posedge clk); #1; valid = 0;
        lat = -1; gu = 0;
        for (int k = 4; k <= 12; k++) begin
            @(posedge clk); #1;
            if (update_out) begin
                if (!gu) lat = k;
                gu = 1;
                if (k != 6) begin
                    n_checks++; n_errors++;
                    $display("FAIL ovf_extra_update: pulse at cycle %0d expected only cycle 6", k);
                end
            end
        end
        check("ovf_latency", 64'(lat), 64'd6);
        check("ovf_flag", 64'(overflow_out), 64'd1);
        check("ovf_gate", 64'(gate_out), 64'd1);
        check("ovf_note", 64'(note_out), 64'd60);
        send_event(1'b1, 8'd62, 8'd80, 4'd0, gu, gs, gi, lat, bz);
        check("ovf_sticky", 64'(overflow_out), 64'd1);
        check("ovf_next_index", 64'(gi), 64'd1);
        do_reset();
        check("ovf_cleared", 64'(overflow_out), 64'd0);

        // Reset in the middle of a scan
        send_event(1'b1, 8'd60, 8'd100, 4'd0, gu, gs, gi, lat, bz);
        @(negedge clk);
        valid = 1; status = 1; note = 8'd62; vel = 8'd100; chan = 4'd0;
        @(posedge clk); #1; valid = 0;
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        check("midrst_gate", 64'(gate_out), 64'd0);
        check("midrst_note", 64'(note_out), 64'd0);
        check("midrst_ready", 64'(ready_out), 64'd1);
        @(negedge clk);
        rst_n = 1;
        gu = 0;
        for (int k = 0; k < NV + 4; k++) begin
            @(posedge clk); #1;
            if (update_out) gu = 1;
        end
        check("midrst_no_update", 64'(gu), 64'd0);
        check("midrst_gate_after", 64'(gate_out), 64'd0);

        // Randomized events against the reference model
        do_reset();
        model_reset();
        for (int it = 0; it < 80; it++) begin
            rs = ($urandom_range(0, 2) != 0);
            rn = 8'(60 + $urandom_range(0, 5));
            rv = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 127));
            rc = 4'($urandom_range(0, 1));
            send_event(rs, rn, rv, rc, gu, gs, gi, lat, bz);
            model_apply(rs, int'(rn), int'(rv), int'(rc), eu, es, ei);
            check($sformatf("rnd%0d_update", it), 64'(gu), 64'(eu));
            if (eu) begin
                check($sformatf("rnd%0d_latency", it), 64'(lat), 64'd6);
                check($sformatf("rnd%0d_steal", it), 64'(gs), 64'(es));
                check($sformatf("rnd%0d_index", it), 64'(gi), 64'(ei));
            end
            check_vs_model($sformatf("rnd%0d", it));
        end
        check("rnd_no_overflow", 64'(overflow_out), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
